// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and tick defaults for button event decoding
package button_pkg;

   // System clock the default tick counts are derived from
   localparam int CLK_HZ = 50_000_000;

   // Default timing: 1 s long press, 200 ms auto-repeat, 2-flop synchronizer
   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_LONG_TICKS   = CLK_HZ;
   localparam int DEF_REPEAT_TICKS = CLK_HZ / 5;
   localparam int DEF_CNT_W        = 26;

   // 2-bit state encodings shared by every consumer of the decoder state
   localparam logic [1:0] ST_WAIT_REL = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_SHORT    = 2'd2;
   localparam logic [1:0] ST_LONG     = 2'd3;

   typedef enum logic [1:0] {
      WAIT_REL = ST_WAIT_REL,
      IDLE     = ST_IDLE,
      SHORT    = ST_SHORT,
      LONG     = ST_LONG
   } btn_state_e;

   // Counter value at which a hold of 'ticks' cycles is complete; 0 ticks maps to 0 (unused)
   function automatic int terminal_count(input int ticks);
      return (ticks == 0) ? 0 : ticks - 1;
   endfunction

endpackage

// File: rtl/level_synchronizer.sv
// rtl/level_synchronizer.sv - generic N-flop level synchronizer with primed flag
module level_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic level_in,
   output logic level_out,
   output logic primed_out
);

   // primed_q shifts a 1 alongside the data so level_out is known to reflect
   // a real post-reset sample of level_in once primed_out is high.
   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic [STAGES-1:0] primed_q;
   logic [STAGES-1:0] primed_d;

   // Next-state of both shift chains
   always_comb begin
      sync_d   = {sync_q[STAGES-2:0], level_in};
      primed_d = {primed_q[STAGES-2:0], 1'b1};
   end

   // Chain registers, cleared synchronously
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '0;
         primed_q <= '0;
      end else begin
         sync_q   <= sync_d;
         primed_q <= primed_d;
      end
   end

   assign level_out  = sync_q[STAGES-1];
   assign primed_out = primed_q[STAGES-1];

endmodule

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - turns a debounced button level into press/release/click/long/repeat strobes
module button_event_decoder
   import button_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       click_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] click_count
);

   localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(terminal_count(LONG_TICKS));
   localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(terminal_count(REPEAT_TICKS));
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam bit               REPEAT_ON = (REPEAT_TICKS != 0);

   logic btn_sync;
   logic sync_primed;

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]       click_count_q, click_count_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             click_q, click_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;

   level_synchronizer #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .level_in  (btn_level),
      .level_out (btn_sync),
      .primed_out(sync_primed)
   );

   // Next-state, hold/click counters and next values of the registered strobes
   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = hold_cnt_q;
      click_count_d = click_count_q;
      press_d       = 1'b0;
      release_d     = 1'b0;
      click_d       = 1'b0;
      long_d        = 1'b0;
      repeat_d      = 1'b0;

      case (state_q)
         // Leave only on a genuine post-reset low sample, so a button held
         // through reset is never reported as a fresh press.
         WAIT_REL: begin
            if (sync_primed && !btn_sync) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (btn_sync) begin
               state_d    = SHORT;
               press_d    = 1'b1;
               hold_cnt_d = '0;
            end
         end

         // Release is tested first so it wins over the long terminal count
         SHORT: begin
            if (!btn_sync) begin
               state_d       = IDLE;
               release_d     = 1'b1;
               click_d       = 1'b1;
               click_count_d = click_count_q + 8'd1;
            end else if (hold_cnt_q == LONG_TC) begin
               state_d    = LONG;
               long_d     = 1'b1;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
         end

         // With repeat disabled the counter just saturates
         LONG: begin
            if (!btn_sync) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else if (REPEAT_ON && (hold_cnt_q == REPEAT_TC)) begin
               repeat_d   = 1'b1;
               hold_cnt_d = '0;
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = WAIT_REL;
         end
      endcase

      held_d = (state_d == SHORT) || (state_d == LONG);
   end

   // State, counters and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= WAIT_REL;
         hold_cnt_q    <= '0;
         click_count_q <= '0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         click_q       <= 1'b0;
         long_q        <= 1'b0;
         repeat_q      <= 1'b0;
         held_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         click_count_q <= click_count_d;
         press_q       <= press_d;
         release_q     <= release_d;
         click_q       <= click_d;
         long_q        <= long_d;
         repeat_q      <= repeat_d;
         held_q        <= held_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign click_pulse   = click_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;
   assign click_count   = click_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - scoreboard bench for button_event_decoder
module tb_button_event_decoder;

   localparam int S = 2;
   localparam int L = 8;
   localparam int R = 4;

   localparam logic [4:0] EV_PRESS = 5'b10000;
   localparam logic [4:0] EV_REL   = 5'b01000;
   localparam logic [4:0] EV_CLICK = 5'b00100;
   localparam logic [4:0] EV_LONG  = 5'b00010;
   localparam logic [4:0] EV_REP   = 5'b00001;

   typedef struct {
      int         cyc;
      logic [4:0] ev;
      logic [7:0] cnt;
      logic       hld;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       click_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       held;
   logic [7:0] click_count;

   int         cyc = 0;
   int         total = 0;
   int         bad = 0;
   int         n_clicks = 0;
   int         c0;
   int         r6;
   logic [7:0] exp_cnt = 8'd0;
   bit         rand_mode = 1'b0;
   exp_t       sb[$];

   button_event_decoder #(
      .SYNC_STAGES (S),
      .LONG_TICKS  (L),
      .REPEAT_TICKS(R),
      .CNT_W       (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .click_pulse  (click_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .click_count  (click_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int c, input logic [4:0] ev, input logic hld, input int cutoff);
      exp_t e;
      if (c < cutoff) begin
         e.cyc = c;
         e.ev  = ev;
         e.cnt = exp_cnt;
         e.hld = hld;
         sb.push_back(e);
      end
   endtask

   // Expected events of one press: btn driven high at cycle r for h cycles
   task automatic gen(input int r, input int h, input int cutoff);
      int p;
      int f;
      p = r + S + 1;
      f = r + h + S + 1;
      push_ev(p, EV_PRESS, 1'b1, cutoff);
      if (f > p + L) begin
         push_ev(p + L, EV_LONG, 1'b1, cutoff);
         for (int t = p + L + R; t < f; t += R) push_ev(t, EV_REP, 1'b1, cutoff);
         push_ev(f, EV_REL, 1'b0, cutoff);
      end else begin
         if (f < cutoff) exp_cnt = exp_cnt + 8'd1;
         push_ev(f, EV_REL | EV_CLICK, 1'b0, cutoff);
      end
   endtask

   task automatic press(input int h, input int gap);
      gen(cyc, h, 32'h4000_0000);
      btn_level = 1'b1;
      repeat (h) step();
      btn_level = 1'b0;
      repeat (gap) step();
   endtask

   task automatic drain(input string tag);
      repeat (S + 3) step();
      chk(tag, sb.size(), 0);
      sb.delete();
   endtask

   task automatic chk_clear(input string tag);
      chk(tag, {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held, click_count}, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      chk_clear("rst_outs");
      reset = 1'b0;
      exp_cnt = 8'd0;
   endtask

   // Output monitor: pops the scoreboard on each event strobe
   always @(negedge clk) begin
      automatic logic [4:0] ev = {press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse};
      automatic exp_t e;
      if (click_pulse) n_clicks = n_clicks + 1;
      if (ev != 5'b0) begin
         if (rand_mode) begin
            chk("strobe_onehot", ($countones(ev & 5'b11011) > 1), 0);
            chk("click_wo_release", click_pulse & ~release_pulse, 0);
         end else if (sb.size() == 0) begin
            chk("unexpected_ev", ev, 0);
         end else begin
            e = sb.pop_front();
            chk("ev_cycle", cyc, e.cyc);
            chk("ev_kind", ev, e.ev);
            chk("ev_click_count", click_count, e.cnt);
            chk("ev_held", held, e.hld);
         end
      end
   end

   initial begin
      reset = 1'b1;
      btn_level = 1'b0;
      step();
      do_reset();

      // 1: short click
      repeat (5) step();
      press(3, 4);
      drain("t1_pending");
      chk("t1_count", click_count, 1);

      // 2: long press with two repeats, no click
      press(20, 4);
      drain("t2_pending");
      chk("t2_count", click_count, 1);

      // 4: release exactly at terminal count, then one cycle later
      press(8, 4);
      press(9, 4);
      drain("t4_pending");
      chk("t4_count", click_count, 2);

      // 3: held through reset -> no press until released
      btn_level = 1'b1;
      reset = 1'b1;
      step();
      step();
      chk_clear("t3_rst");
      reset = 1'b0;
      exp_cnt = 8'd0;
      repeat (12) step();
      chk("t3_held", held, 0);
      drain("t3_nopress");
      btn_level = 1'b0;
      step();
      press(3, 4);
      drain("t3_pending");
      chk("t3_count", click_count, 1);

      // 5: 256 clicks wrap the counter
      do_reset();
      repeat (5) step();
      c0 = n_clicks;
      repeat (256) press(2, 3);
      drain("t5_pending");
      chk("t5_count", click_count, 0);
      chk("t5_pulses", n_clicks - c0, 256);

      // 6: reset while in LONG, then random toggling
      r6 = cyc;
      gen(r6, 1000, r6 + 15);
      btn_level = 1'b1;
      repeat (14) step();
      reset = 1'b1;
      step();
      chk_clear("t6_rst");
      step();
      reset = 1'b0;
      exp_cnt = 8'd0;
      chk("t6_pending", sb.size(), 0);
      repeat (10) step();
      btn_level = 1'b0;
      repeat (10) step();
      drain("t6_norel");
      chk("t6_count", click_count, 0);

      rand_mode = 1'b1;
      repeat (60) begin
         btn_level = 1'($urandom % 2);
         repeat ($urandom_range(1, 14)) step();
      end
      btn_level = 1'b0;
      repeat (10) step();
      rand_mode = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
